cmd_seq_demux: RTL

Receiving end of the sequencer command bus: accepts address/data commands from a single command-bus initiator using the `wr_en`/`ackn` handshake. Buffers the commands in a small FIFO, decodes each address against four address windows and delivers the command in order to one of four register-block targets, each with its own valid/ready handshake. Sits between the command-bus arbiter output and the per-subsystem register files; commands whose address matches no window are dropped and flagged.

---
 rtl/cmd_seq_pkg.sv | 30 +++
 rtl/cmd_fifo_sync.sv | 67 ++++++
 rtl/cmd_seq_demux.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cmd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cmd_seq_pkg
// Brief   : Shared types, constants and window-match helper for cmd_seq_demux.
// Revision: 1.0 - initial release
// ============================================================================
package cmd_seq_pkg;

    localparam int CMD_NUM_TGT   = 4;
    localparam int CMD_SEL_BITS  = $clog2(CMD_NUM_TGT);
    localparam int CMD_ADDR_MAX  = 32;
    localparam int CMD_DATA_BITS = 32;

    // Address is carried at its maximum width so the record is independent
    // of the instance address width; narrower addresses are zero-extended.
    typedef struct packed {
        logic [CMD_ADDR_MAX-1:0]  addr;
        logic [CMD_DATA_BITS-1:0] data;
    } cmd_t;

    function automatic logic win_match(
        input logic [CMD_ADDR_MAX-1:0] addr,
        input logic [CMD_ADDR_MAX-1:0] base,
        input logic [CMD_ADDR_MAX-1:0] mask
    );
        return (addr & mask) == base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module  : cmd_fifo_sync
// Brief   : Single-clock register FIFO with push/pop, full/empty and level.
// Revision: 1.0 - initial release
// ============================================================================
module cmd_fifo_sync #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (level == LEVEL_FULL);
    assign empty    = (level == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH because they are DEPTH_LOG2 bits wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmd_seq_demux.sv
`default_nettype none
// ============================================================================
// Module  : cmd_seq_demux
// Brief   : Buffers command-bus writes and routes them in order to four
//           address-window targets; unmapped commands are dropped and flagged.
// Revision: 1.0 - initial release
// ============================================================================
module cmd_seq_demux
    import cmd_seq_pkg::*;
#(
    parameter int                          AXI_WR_ADDR_BITS = 14,
    parameter int                          FIFO_DEPTH_LOG2  = 2,
    parameter logic [AXI_WR_ADDR_BITS-1:0] BASE0 = 14'h0000,
    parameter logic [AXI_WR_ADDR_BITS-1:0] BASE1 = 14'h0400,
    parameter logic [AXI_WR_ADDR_BITS-1:0] BASE2 = 14'h0800,
    parameter logic [AXI_WR_ADDR_BITS-1:0] BASE3 = 14'h0c00,
    parameter logic [AXI_WR_ADDR_BITS-1:0] MASK0 = 14'h3c00,
    parameter logic [AXI_WR_ADDR_BITS-1:0] MASK1 = 14'h3c00,
    parameter logic [AXI_WR_ADDR_BITS-1:0] MASK2 = 14'h3c00,
    parameter logic [AXI_WR_ADDR_BITS-1:0] MASK3 = 14'h3c00
) (
    input  logic                          mclk,
    input  logic                          rst_n,
    input  logic [AXI_WR_ADDR_BITS-1:0]   waddr_in,
    input  logic                          wr_en_in,
    input  logic [CMD_DATA_BITS-1:0]      wdata_in,
    output logic                          ackn_in,
    output logic [AXI_WR_ADDR_BITS-1:0]   tgt_addr,
    output logic [CMD_DATA_BITS-1:0]      tgt_data,
    output logic [CMD_NUM_TGT-1:0]        tgt_valid,
    input  logic [CMD_NUM_TGT-1:0]        tgt_ready,
    output logic [FIFO_DEPTH_LOG2:0]      fifo_level,
    output logic                          miss_err,
    input  logic                          miss_clr
);

    localparam logic [AXI_WR_ADDR_BITS-1:0] WIN_BASE [CMD_NUM_TGT] = '{BASE0, BASE1, BASE2, BASE3};
    localparam logic [AXI_WR_ADDR_BITS-1:0] WIN_MASK [CMD_NUM_TGT] = '{MASK0, MASK1, MASK2, MASK3};

    cmd_t                    push_cmd;
    cmd_t                    head_cmd;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    out_full;
    logic                    out_accept;
    logic                    any_hit;
    logic [CMD_NUM_TGT-1:0]  hit;
    logic [CMD_SEL_BITS-1:0] hit_sel;
    logic [CMD_SEL_BITS-1:0] tgt_sel;

    always_comb begin
        push_cmd      = '0;
        push_cmd.addr = CMD_ADDR_MAX'(waddr_in);
        push_cmd.data = wdata_in;
    end

    assign ackn_in = wr_en_in & ~fifo_full;
    assign push    = ackn_in;

    cmd_fifo_sync #(
        .WIDTH      ($bits(cmd_t)),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (mclk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_cmd),
        .pop       (pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    for (genvar g = 0; g < CMD_NUM_TGT; g++) begin : g_win
        assign hit[g] = win_match(head_cmd.addr,
                                  CMD_ADDR_MAX'(WIN_BASE[g]),
                                  CMD_ADDR_MAX'(WIN_MASK[g]));
    end

    // Lowest-index window wins when several match.
    always_comb begin
        hit_sel = '0;
        any_hit = |hit;
        for (int i = CMD_NUM_TGT - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_sel = CMD_SEL_BITS'(i);
            end
        end
    end

    assign out_accept = out_full & tgt_ready[tgt_sel];
    assign pop        = ~fifo_empty & (~out_full | out_accept);

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            out_full <= 1'b0;
            tgt_sel  <= '0;
            tgt_addr <= '0;
            tgt_data <= '0;
        end else if (pop) begin
            // An unmapped head leaves the stage empty; it was either already
            // empty or is being accepted this cycle.
            out_full <= any_hit;
            if (any_hit) begin
                tgt_sel  <= hit_sel;
                tgt_addr <= head_cmd.addr[AXI_WR_ADDR_BITS-1:0];
                tgt_data <= head_cmd.data;
            end
        end else if (out_accept) begin
            out_full <= 1'b0;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            miss_err <= 1'b0;
        end else if (pop & ~any_hit) begin
            miss_err <= 1'b1;
        end else if (miss_clr) begin
            miss_err <= 1'b0;
        end
    end

    always_comb begin
        tgt_valid = '0;
        if (out_full) begin
            tgt_valid[tgt_sel] = 1'b1;
        end
    end

endmodule
`default_nettype wire
